// File: rtl/fp_div64.sv
// rtl/fp_div64.sv - IEEE-754 double divider, restoring, one quotient bit per cycle (optional rounding: FP_DIV_ROUND_EN)
module fp_div64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [63:0] A,
    input  logic [63:0] B,
    output logic [63:0] result,
    output logic        busy,
    output logic        done
);

`ifdef FP_DIV_ROUND_EN
    localparam int QW = 55;
`else
    localparam int QW = 54;
`endif
    localparam logic [5:0] LAST = 6'(QW - 1);

    typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;

    state_t         state_q, state_d;
    logic           sign_q, sign_d;
    logic [10:0]    ea_q, ea_d;
    logic [10:0]    eb_q, eb_d;
    logic [53:0]    rem_q, rem_d;
    logic [52:0]    div_q, div_d;
    logic [QW-1:0]  quo_q, quo_d;
    logic [5:0]     cnt_q, cnt_d;
    logic           spec_q, spec_d;
    logic [63:0]    spec_res_q, spec_res_d;
    logic [63:0]    result_q, result_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic               ge;
    logic [53:0]        rem_sub;
    logic signed [12:0] exp_n;
    logic [51:0]        mant_n;
    logic [63:0]        norm_res;
`ifdef FP_DIV_ROUND_EN
    logic        lead, guard, sticky, rnd, carry;
    logic [51:0] mant_t;
`endif

    // Normalise the raw quotient into exponent/mantissa and clamp under/overflow
    always_comb begin
        exp_n = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q})
              + (quo_q[QW-1] ? 13'sd1023 : 13'sd1022);
`ifdef FP_DIV_ROUND_EN
        lead   = quo_q[54];
        mant_t = lead ? quo_q[53:2] : quo_q[52:1];
        guard  = lead ? quo_q[1] : quo_q[0];
        // Bits below the guard (leftover quotient bit and remainder) form the sticky bit
        sticky = (lead & quo_q[0]) | (|rem_q);
        rnd    = guard & (sticky | mant_t[0]);
        {carry, mant_n} = {1'b0, mant_t} + 53'(rnd);
        if (carry) begin
            exp_n = exp_n + 13'sd1;
        end
`else
        mant_n = quo_q[QW-1] ? quo_q[52:1] : quo_q[51:0];
`endif
        if (exp_n <= 13'sd0) begin
            norm_res = {sign_q, 63'h0};
        end else if (exp_n >= 13'sd2047) begin
            norm_res = {sign_q, 11'h7FF, 52'h0};
        end else begin
            norm_res = {sign_q, exp_n[10:0], mant_n};
        end
    end

    // FSM next state, operand capture and one restoring-division step
    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        ea_d       = ea_q;
        eb_d       = eb_q;
        rem_d      = rem_q;
        div_d      = div_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        result_d   = result_q;
        busy_d     = busy_q;
        done_d     = done_q;

        ge      = rem_q >= {1'b0, div_q};
        rem_sub = ge ? (rem_q - {1'b0, div_q}) : rem_q;

        if (en) begin
            done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (load && !busy_q) begin
                        sign_d = A[63] ^ B[63];
                        ea_d   = A[62:52];
                        eb_d   = B[62:52];
                        rem_d  = {2'b01, A[51:0]};
                        div_d  = {1'b1, B[51:0]};
                        quo_d  = '0;
                        cnt_d  = 6'd0;
                        busy_d = 1'b1;
                        spec_d = 1'b1;
                        if (A[62:52] == 11'h7FF || B[62:52] == 11'h7FF) begin
                            spec_res_d = 64'h7FF8000000000000;
                        end else if (B[62:52] == 11'h000) begin
                            spec_res_d = {A[63] ^ B[63], 11'h7FF, 52'h0};
                        end else if (A[62:52] == 11'h000) begin
                            spec_res_d = {A[63] ^ B[63], 63'h0};
                        end else begin
                            spec_d     = 1'b0;
                            spec_res_d = 64'h0;
                        end
                        state_d = spec_d ? NORM : DIV;
                    end
                end
                DIV: begin
                    rem_d = rem_sub << 1;
                    quo_d = {quo_q[QW-2:0], ge};
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == LAST) begin
                        state_d = NORM;
                    end
                end
                NORM: begin
                    result_d = spec_q ? spec_res_q : norm_res;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sign_q     <= 1'b0;
            ea_q       <= 11'h0;
            eb_q       <= 11'h0;
            rem_q      <= 54'h0;
            div_q      <= 53'h0;
            quo_q      <= '0;
            cnt_q      <= 6'd0;
            spec_q     <= 1'b0;
            spec_res_q <= 64'h0;
            result_q   <= 64'h0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            ea_q       <= ea_d;
            eb_q       <= eb_d;
            rem_q      <= rem_d;
            div_q      <= div_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_fp_div64.sv
// tb/tb_fp_div64.sv - directed self-checking bench for fp_div64
module tb_fp_div64;

`ifdef FP_DIV_ROUND_EN
    localparam int          LAT      = 56;
    localparam logic [63:0] ONE_TENTH = 64'h3FB999999999999A;
`else
    localparam int          LAT      = 55;
    localparam logic [63:0] ONE_TENTH = 64'h3FB9999999999999;
`endif

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [63:0] A;
    logic [63:0] B;
    logic [63:0] result;
    logic        busy;
    logic        done;

    int n_cmp;
    int n_err;
    int n;

    fp_div64 dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .load   (load),
        .A      (A),
        .B      (B),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge with the divider idle (or done high)
    task automatic start(input logic [63:0] a, input logic [63:0] b);
        A    = a;
        B    = b;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) break;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        en    = 1'b1;
        load  = 1'b0;
        A     = 64'h0;
        B     = 64'h0;
        #12;
        chk("reset_result", result, 64'h0);
        chk("reset_busy", {63'h0, busy}, 64'h0);
        chk("reset_done", {63'h0, done}, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        start(64'h4018000000000000, 64'h4000000000000000);
        chk("busy_after_accept", {63'h0, busy}, 64'h1);
        wait_done(n);
        chk("lat_6div2", 64'(n), 64'(LAT));
        chk("res_6div2", result, 64'h4008000000000000);
        chk("busy_at_done", {63'h0, busy}, 64'h0);

        // en low while done is high keeps the pulse; next enabled edge clears it
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("done_hold_en_low", {63'h0, done}, 64'h1);
        en = 1'b1;
        @(posedge clk);
        #1;
        chk("done_clears", {63'h0, done}, 64'h0);
        chk("result_holds", result, 64'h4008000000000000);

        start(64'hC020000000000000, 64'h3FE0000000000000);
        wait_done(n);
        chk("res_m8div05", result, 64'hC030000000000000);

        // Back-to-back: load accepted in the cycle done is high
        start(64'h3FF0000000000000, 64'h4024000000000000);
        wait_done(n);
        chk("lat_1div10_b2b", 64'(n), 64'(LAT));
        chk("res_1div10", result, ONE_TENTH);

        start(64'h3FF0000000000000, 64'h0000000000000000);
        wait_done(n);
        chk("lat_div0", 64'(n), 64'd1);
        chk("res_div0", result, 64'h7FF0000000000000);

        start(64'h0000000000000000, 64'h4000000000000000);
        wait_done(n);
        chk("lat_zero", 64'(n), 64'd1);
        chk("res_zero", result, 64'h0);

        start(64'h7FF0000000000000, 64'h3FF0000000000000);
        wait_done(n);
        chk("lat_inf", 64'(n), 64'd1);
        chk("res_inf", result, 64'h7FF8000000000000);

        // load while busy is ignored
        start(64'h4018000000000000, 64'h4000000000000000);
        repeat (19) @(posedge clk);
        #1;
        A    = 64'hC020000000000000;
        B    = 64'h3FE0000000000000;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        wait_done(n);
        chk("lat_load_ignored", 64'(n + 20), 64'(LAT));
        chk("res_load_ignored", result, 64'h4008000000000000);

        // en low for 10 cycles stretches latency by 10
        start(64'hC020000000000000, 64'h3FE0000000000000);
        repeat (10) @(posedge clk);
        #1;
        en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("busy_frozen", {63'h0, busy}, 64'h1);
        chk("result_frozen", result, 64'h4008000000000000);
        en = 1'b1;
        wait_done(n);
        chk("lat_en_stretch", 64'(n + 20), 64'(LAT + 10));
        chk("res_en_stretch", result, 64'hC030000000000000);

        // Asynchronous reset mid-divide
        start(64'h3FF0000000000000, 64'h4024000000000000);
        repeat (30) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_result", result, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("no_done_after_rst", {63'h0, done}, 64'h0);
        start(64'h4018000000000000, 64'h4000000000000000);
        wait_done(n);
        chk("lat_after_rst", 64'(n), 64'(LAT));
        chk("res_after_rst", result, 64'h4008000000000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp_div64.md
# fp_div64

- IEEE-754 double-precision divider: result = A / B.
- Sequential restoring-division datapath, one quotient bit per cycle, with a load/done handshake.
- Inverse companion to the FP64 multiplier in the floating-point calculator datapath; shares its operand-load style (`load`/`en`, operands `A`, `B`, output `result`).
- Sits beside the multiplier behind the calculator's operation select.

## Interface
Parameters:
- none.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset: low forces reset immediately; release is synchronous to `clk`.
- `en`  in  1  clock enable; low freezes every register, including `done`.
- `load`  in  1  with `en` high and `busy` low, captures `A`/`B` and starts a divide.
- `A`  in  64  dividend, IEEE-754 double.
- `B`  in  64  divisor, IEEE-754 double.
- `result`  out  64  quotient; holds its value until the next completion.
- `busy`  out  1  high from the accept edge until the completion edge.
- `done`  out  1  one-enabled-cycle pulse; `result` is valid while `done` is high and after it.

## Operation
- States: IDLE, DIV, NORM.
- IDLE, on accept (`en & load & ~busy`):
  - capture sign = A[63]^B[63], exponents, mantissas {1,frac}, a 53-bit zero-extended remainder, and a 6-bit iteration counter = 0;
  - set `busy`.
- Special operands are classified at accept, and the FSM goes straight to NORM with a preset result:
  - either exponent = 0x7FF -> quiet NaN 0x7FF8000000000000, sign 0;
  - B exponent = 0 (zero/denormal treated as zero) -> {sign, 0x7FF, 52'h0};
  - otherwise A exponent = 0 -> {sign, 63'h0}.
- DIV, per enabled cycle:
  - if rem >= divisor, quotient bit = 1 and rem -= divisor, else quotient bit = 0;
  - rem <<= 1, quotient <<= 1 | bit, counter++;
  - 54 iterations, plus 1 when rounding is enabled. After the last iteration go to NORM.
- NORM (one cycle):
  - exponent is 13-bit signed: E = Ea − Eb + 1023 if Q[53] = 1, else Ea − Eb + 1022;
  - mantissa = Q[52:1] if Q[53] = 1, else Q[51:0];
  - if E <= 0: result = {sign, 63'h0}; if E >= 2047: result = {sign, 0x7FF, 52'h0};
  - register `result`, pulse `done`, clear `busy`, go to IDLE.
- `load` while `busy` is ignored; operands are not re-captured.
- `done` clears on the next enabled edge.

## Timing
- Reset values: `result` = 0, `busy` = 0, `done` = 0, state IDLE, all internal registers 0.
- Accept at enabled edge k; normal latency counts enabled edges only:
  - without rounding, `done` is high after edge k+55;
  - with rounding, after edge k+56.
- Special operands: `done` is high after edge k+1.
- Cycles with `en` low stretch the latency 1:1, and outputs hold.
- Back-to-back: a new `load` is accepted in the same cycle `done` is high, since `busy` is already low.
- `rst` asserted mid-divide aborts at once: outputs go to 0 and no `done` is produced.

## Configuration
- `FP_DIV_ROUND_EN` defined:
  - one extra DIV iteration produces a guard bit;
  - NORM computes sticky = |rem and applies round-to-nearest-even;
  - if rounding carries out of the mantissa, mantissa = 0 and E is incremented, and the overflow check applies after that increment.
- Undefined: the quotient is truncated toward zero and the extra iteration is absent.

## Test plan
- 0x4018000000000000 / 0x4000000000000000 (6/2) -> 0x4008000000000000; `done` 55 enabled cycles after accept (56 with `FP_DIV_ROUND_EN`).
- 0xC020000000000000 / 0x3FE0000000000000 (−8/0.5) -> 0xC030000000000000.
- 0x3FF0000000000000 / 0x4024000000000000 (1/10) -> 0x3FB9999999999999 truncated; 0x3FB999999999999A with `FP_DIV_ROUND_EN`.
- 0x3FF0000000000000 / 0 -> 0x7FF0000000000000; 0 / 0x4000000000000000 -> 0; 0x7FF0000000000000 / 1.0 -> 0x7FF8000000000000; each with `done` 1 cycle after accept.
- Pulse `load` with new operands at cycle 20 of a divide -> ignored, original quotient returned; toggle `en` low for 10 cycles mid-divide -> latency +10, same result.
- Drive `rst` low at cycle 30 of a divide -> `busy`/`done`/`result` = 0 immediately; after release a fresh 6/2 completes normally.
